// File: rtl/gates_registered.sv
// gates_registered: bitwise two-input logic unit with registered results.
// One-cycle latency; in_valid gates capture, results hold otherwise.
module gates_registered #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] And,
  output logic [WIDTH-1:0] Or,
  output logic [WIDTH-1:0] Nor,
  output logic [WIDTH-1:0] Nand,
  output logic [WIDTH-1:0] Xor,
  output logic [WIDTH-1:0] Xnor,
  output logic [WIDTH-1:0] Not,
  output logic             out_valid
);

  logic [WIDTH-1:0] and_q, and_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic [WIDTH-1:0] nor_q, nor_d;
  logic [WIDTH-1:0] nand_q, nand_d;
  logic [WIDTH-1:0] xor_q, xor_d;
  logic [WIDTH-1:0] xnor_q, xnor_d;
  logic [WIDTH-1:0] not_q, not_d;
  logic             vld_q, vld_d;

  // Next state: load gate functions on valid input, otherwise hold.
  always_comb begin
    and_d  = and_q;
    or_d   = or_q;
    nor_d  = nor_q;
    nand_d = nand_q;
    xor_d  = xor_q;
    xnor_d = xnor_q;
    not_d  = not_q;
    vld_d  = in_valid;
    if (in_valid) begin
      and_d  = A & B;
      or_d   = A | B;
      nor_d  = ~(A | B);
      nand_d = ~(A & B);
      xor_d  = A ^ B;
      xnor_d = ~(A ^ B);
      not_d  = ~A;
    end
  end

  // Result registers; reset clears everything, including inverted outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_q  <= '0;
      or_q   <= '0;
      nor_q  <= '0;
      nand_q <= '0;
      xor_q  <= '0;
      xnor_q <= '0;
      not_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      and_q  <= and_d;
      or_q   <= or_d;
      nor_q  <= nor_d;
      nand_q <= nand_d;
      xor_q  <= xor_d;
      xnor_q <= xnor_d;
      not_q  <= not_d;
      vld_q  <= vld_d;
    end
  end

  assign And       = and_q;
  assign Or        = or_q;
  assign Nor       = nor_q;
  assign Nand      = nand_q;
  assign Xor       = xor_q;
  assign Xnor      = xnor_q;
  assign Not       = not_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_gates_registered.sv
// tb_gates_registered: directed checks for gates_registered.
// Runs a WIDTH=1 and a WIDTH=8 instance side by side.
module tb_gates_registered;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic [0:0] and1, or1, nor1, nand1, xor1, xnor1, not1;
  logic       ov1;
  logic [7:0] and8, or8, nor8, nand8, xor8, xnor8, not8;
  logic       ov8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gates_registered #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a1), .B(b1),
    .And(and1), .Or(or1), .Nor(nor1), .Nand(nand1),
    .Xor(xor1), .Xnor(xnor1), .Not(not1),
    .out_valid(ov1)
  );

  gates_registered #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a8), .B(b8),
    .And(and8), .Or(or8), .Nor(nor8), .Nand(nand8),
    .Xor(xor8), .Xnor(xnor8), .Not(not8),
    .out_valid(ov8)
  );

  // expected packing {And,Or,Nor,Nand,Xor,Xnor,Not}
  localparam logic [6:0] T00 = 7'b0011011;
  localparam logic [6:0] T01 = 7'b0101101;
  localparam logic [6:0] T10 = 7'b0101100;
  localparam logic [6:0] T11 = 7'b1100010;
  localparam logic [6:0] TZ  = 7'b0000000;

  task automatic drive(input logic r, input logic v,
                       input logic a, input logic b,
                       input logic [7:0] aw, input logic [7:0] bw);
    rst      = r;
    in_valid = v;
    a1       = a;
    b1       = b;
    a8       = aw;
    b8       = bw;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [6:0] exp,
                      input logic expv);
    logic [6:0] obs;
    obs = {and1, or1, nor1, nand1, xor1, xnor1, not1};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s res1 obs=%b exp=%b", tag, obs, exp);
    end
    total++;
    assert (ov1 === expv) else begin
      bad++;
      $error("FAIL %s ov1 obs=%b exp=%b", tag, ov1, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [55:0] exp,
                      input logic expv);
    logic [55:0] obs;
    obs = {and8, or8, nor8, nand8, xor8, xnor8, not8};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s res8 obs=%h exp=%h", tag, obs, exp);
    end
    total++;
    assert (ov8 === expv) else begin
      bad++;
      $error("FAIL %s ov8 obs=%b exp=%b", tag, ov8, expv);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    #2;

    // reset with in_valid high and ones on inputs
    drive(1, 1, 1, 1, 8'hFF, 8'hFF);
    chk1("rst_c1", TZ, 1'b0);
    chk8("rst8_c1", 56'h0, 1'b0);
    drive(1, 1, 1, 1, 8'hFF, 8'hFF);
    chk1("rst_c2", TZ, 1'b0);
    chk8("rst8_c2", 56'h0, 1'b0);
    drive(0, 1, 1, 1, 8'hFF, 8'hFF);
    chk1("rst_rel", T11, 1'b1);

    // truth table, one capture each
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    chk1("tt00", T00, 1'b1);
    drive(0, 1, 0, 1, 8'h00, 8'h00);
    chk1("tt01", T01, 1'b1);
    drive(0, 1, 1, 0, 8'h00, 8'h00);
    chk1("tt10", T10, 1'b1);
    drive(0, 1, 1, 1, 8'h00, 8'h00);
    chk1("tt11", T11, 1'b1);

    // hold: capture 10 then idle with different inputs
    drive(0, 1, 1, 0, 8'hA5, 8'h3C);
    chk1("hold_cap", T10, 1'b1);
    chk8("w8_a5_3c", {8'h24, 8'hBD, 8'h42, 8'hDB,
                      8'h99, 8'h66, 8'h5A}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 8'h0F, 8'hF0);
      chk1("hold", T10, 1'b0);
      chk8("hold8", {8'h24, 8'hBD, 8'h42, 8'hDB,
                     8'h99, 8'h66, 8'h5A}, 1'b0);
    end

    // second wide vector
    drive(0, 1, 0, 0, 8'hFF, 8'h00);
    chk8("w8_ff_00", {8'h00, 8'hFF, 8'h00, 8'hFF,
                      8'hFF, 8'h00, 8'h00}, 1'b1);
    drive(0, 1, 0, 0, 8'h96, 8'h96);
    chk8("w8_96_96", {8'h96, 8'h96, 8'h69, 8'h69,
                      8'h00, 8'hFF, 8'h69}, 1'b1);

    // streaming, no bubbles
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    chk1("pre_stream", T00, 1'b0);
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    chk1("st00", T00, 1'b1);
    drive(0, 1, 0, 1, 8'h00, 8'h00);
    chk1("st01", T01, 1'b1);
    drive(0, 1, 1, 0, 8'h00, 8'h00);
    chk1("st10", T10, 1'b1);
    drive(0, 1, 1, 1, 8'h00, 8'h00);
    chk1("st11", T11, 1'b1);

    // reset mid-stream
    drive(0, 1, 0, 1, 8'h00, 8'h00);
    chk1("ms01", T01, 1'b1);
    drive(1, 1, 1, 0, 8'hAA, 8'h55);
    chk1("ms_rst", TZ, 1'b0);
    chk8("ms_rst8", 56'h0, 1'b0);
    drive(0, 1, 0, 0, 8'hA5, 8'h3C);
    chk1("ms_resume", T00, 1'b1);
    chk8("ms_resume8", {8'h24, 8'hBD, 8'h42, 8'hDB,
                        8'h99, 8'h66, 8'h5A}, 1'b1);
    drive(0, 0, 1, 1, 8'h00, 8'h00);
    chk1("ms_idle", T00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
